fir_stream_ctrl: RTL and testbench
==================================

# fir_stream_ctrl

Frame-level sequencer for the 16-bit-in / 26-bit-out low-cost transposed 6-tap FIR core. Buffers incoming samples and primes the core with a gap-free burst. Drains the core's tail with zeros so its delay line is clear at every frame end. Tags the core's free-running output with valid/last. Sits between the upstream sample source and the FIR core; the core instance stays outside this block.

## Interface
- DW, 16, input sample width (core input width)
- OW, 26, core output width
- DEPTH, 8, sample FIFO depth (power of two)
- PRIME, 4, FIFO occupancy required to start a frame
- TAPS, 6, filter taps; the drain length is TAPS-1
- LATENCY, 2, clocks from `fir_a` to the matching `fir_b`
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  FIFO can accept (= not full)
- in_data  in  DW  signed sample
- in_last  in  1  final sample of frame
- fir_a  out  DW  sample to core input `a`
- fir_b  in  OW  core output `b`
- out_valid  out  1  `out_data` is a filter output of the current frame
- out_data  out  OW  registered copy of `fir_b`
- out_last  out  1  final output of frame
- busy  out  1  high in RUN, in DRAIN, or while tags are in flight
- underrun  out  1  sticky: FIFO ran empty inside a frame
- clr_err  in  1  synchronous clear of `underrun`

## Operation
- FIFO: synchronous, DEPTH entries of {last, data}.
  - Push on in_valid && in_ready.
  - Pop only in RUN.
  - Simultaneous push and pop is legal whenever not full. The count is unchanged.
- `last_pending` counter: +1 when a last is pushed, -1 when a last is popped.
- States:
  - IDLE:
    - fir_a = 0.
    - Go to RUN when count ≥ PRIME or last_pending ≠ 0.
  - RUN:
    - Each cycle, if the FIFO is non-empty: pop the head and drive fir_a = head data.
    - If the FIFO is empty: drive fir_a = 0, count it as a sample, set `underrun`.
    - When a popped entry has last=1, go to DRAIN with drain_cnt = TAPS-2.
  - DRAIN:
    - fir_a = 0.
    - drain_cnt decrements each cycle.
    - At 0, go to IDLE.
    - The DRAIN cycle with drain_cnt = 0 is tagged last.
- Tag pipeline: LATENCY-stage shift register of {valid, last}.
  - Input valid = RUN or DRAIN.
  - Input last = DRAIN && drain_cnt==0.
- Output register each cycle:
  - out_data ← fir_b.
  - out_valid/out_last ← tag-pipeline head.
- A frame of N input samples yields exactly N+TAPS-1 contiguous out_valid cycles. out_last is on the final one.
- No backpressure on the output side: the consumer accepts every out_valid cycle.
- Arithmetic: no arithmetic on the data path.
  - fir_a passes through or is zero.
  - out_data is the unmodified 26-bit core output.
- Counter widths: count uses $clog2(DEPTH)+1 bits. drain_cnt uses $clog2(TAPS) bits.
- Between frames, IDLE drives zeros, so the core's state stays cleared.
- Back-to-back frames: the next frame starts only after DRAIN completes.
- Reset (asynchronous, any state) forces:
  - state=IDLE, FIFO empty, last_pending=0, tags=0
  - out_valid=0, out_last=0, out_data=0
  - underrun=0, fir_a=0
  - in_ready=1 after reset release
- Reset is shared with the core, so the core clears at the same time.
- clr_err and a new underrun in the same cycle: set wins.

## Timing
- IDLE→RUN: the decision uses the registered count. The first RUN cycle follows the cycle in which the condition is true.
- fir_a is combinational from state and FIFO head; it is valid in the same cycle as the pop.
- First out_valid: LATENCY+1 = 3 clocks after the first RUN cycle (core latency plus the output register).
- in_ready is combinational from the registered count. It is low only when count == DEPTH.
- busy falls the cycle after out_last is presented.

## Structure
- Shared package `fir_pkg`:
  - DW, OW, TAPS, LATENCY constants.
  - State enum (IDLE, RUN, DRAIN).
  - Sample struct {last, data}.
- Sub-module `sample_fifo`: parameterized synchronous FIFO with count, full, empty, and head peek.
- The controller contains the FSM, drain counter, tag shift register, output register, and error flag.

## Test plan
- Single frame, impulse:
  - Stimulus: N=1, data=16'sd1000, last=1.
  - Expect RUN starts via last_pending.
  - Expect 6 out_valid cycles, the first 3 clocks after RUN.
  - Expect out_data to match the golden core model for 1000 at taps 0..5.
  - Expect out_last on the 6th; busy low afterwards.
- Steady frame:
  - Stimulus: 4 samples {100,-200,300,-400}, last on the 4th.
  - Expect 9 contiguous valid outputs matching the golden convolution, out_last on the 9th.
- Full FIFO:
  - Stimulus: push 8 samples with no last while the FSM is forced to stay in IDLE by PRIME=8 override.
  - Expect in_ready=0 at count 8.
  - Expect RUN begins the next cycle; in_ready returns to 1 after the first pop.
- Underrun:
  - Stimulus: push 4 samples, stop (no last), then send the 5th sample with last after 3 idle cycles.
  - Expect 3 zero samples inserted and underrun=1.
  - Expect a total of 8+5 valid outputs.
  - Expect clr_err to clear underrun.
- Back-to-back frames:
  - Stimulus: frame A (2 samples) immediately followed by frame B (3 samples).
  - Expect 7 outputs with out_last, then ≥1 IDLE cycle, then 8 outputs.
  - Expect B's outputs to be free of any A contribution.
- Reset mid-frame:
  - Stimulus: assert reset in RUN with 3 entries queued.
  - Expect all outputs 0 immediately (asynchronous) and the FIFO empty.
  - Expect a subsequent 1-sample frame to produce exactly 6 correct outputs.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants, FSM state type and FIFO entry type for the
//                FIR stream sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int C_DW      = 16;  // core input sample width
    localparam int C_OW      = 26;  // core output width
    localparam int C_TAPS    = 6;   // filter taps
    localparam int C_LATENCY = 2;   // clocks from core input to matching output

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                   last;
        logic signed [C_DW-1:0] data;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous FIFO with occupancy count, full/empty flags and
//                a combinational peek at the head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_stream_ctrl
//  Description : Frame sequencer for a transposed FIR core. Buffers samples,
//                primes the core with a gap-free burst, flushes the core's
//                delay line with zeros and tags the core output valid/last.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_ctrl
    import fir_pkg::*;
#(
    parameter int DW      = C_DW,
    parameter int OW      = C_OW,
    parameter int DEPTH   = 8,
    parameter int PRIME   = 4,
    parameter int TAPS    = C_TAPS,
    parameter int LATENCY = C_LATENCY
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic [DW-1:0] fir_a,
    input  logic [OW-1:0] fir_b,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          underrun,
    input  logic          clr_err
);

    localparam int             CW           = $clog2(DEPTH) + 1;
    localparam int             DCW          = $clog2(TAPS);
    localparam logic [DCW-1:0] C_DRAIN_INIT = DCW'(TAPS - 2);

    sample_t              w_push_entry;
    sample_t              w_head;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_push;
    logic                 w_last_pop;
    logic                 w_underrun_set;
    logic                 w_tag_v_in;
    logic                 w_tag_l_in;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [DCW-1:0]       r_drain_cnt;
    logic [DCW-1:0]       w_drain_nxt;
    logic [CW-1:0]        r_last_pending;
    logic [LATENCY-1:0]   r_tag_v;
    logic [LATENCY-1:0]   r_tag_l;

    assign w_push_entry = '{last: in_last, data: in_data};
    assign in_ready     = !w_full;
    assign w_push       = in_valid && in_ready;
    assign w_last_push  = w_push && in_last;
    assign w_last_pop   = w_pop && w_head.last;
    assign busy         = (r_state != IDLE) || (|r_tag_v) || out_valid;

    sample_fifo #(
        .WIDTH ($bits(sample_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_push_entry),
        .pop   (w_pop),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next state, pop strobe, core input and tag inputs for the frame sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_drain_nxt    = r_drain_cnt;
        w_pop          = 1'b0;
        fir_a          = '0;
        w_underrun_set = 1'b0;
        w_tag_v_in     = 1'b0;
        w_tag_l_in     = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_count >= CW'(PRIME)) || (r_last_pending != '0)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_tag_v_in = 1'b1;
                if (!w_empty) begin
                    w_pop = 1'b1;
                    fir_a = w_head.data;
                    if (w_head.last) begin
                        w_state_nxt = DRAIN;
                        w_drain_nxt = C_DRAIN_INIT;
                    end
                end else begin
                    // Starved: a zero stands in for the missing sample.
                    w_underrun_set = 1'b1;
                end
            end
            DRAIN: begin
                w_tag_v_in = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_tag_l_in  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_drain_nxt = r_drain_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, drain counter and count of frame ends still buffered in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_drain_cnt    <= '0;
            r_last_pending <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            case ({w_last_push, w_last_pop})
                2'b10:   r_last_pending <= r_last_pending + 1'b1;
                2'b01:   r_last_pending <= r_last_pending - 1'b1;
                default: r_last_pending <= r_last_pending;
            endcase
        end
    end

    // Tag delay matching the core latency, then the output register and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v   <= '0;
            r_tag_l   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            underrun  <= 1'b0;
        end else begin
            r_tag_v[0] <= w_tag_v_in;
            r_tag_l[0] <= w_tag_l_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
            out_valid <= r_tag_v[LATENCY-1];
            out_last  <= r_tag_l[LATENCY-1];
            out_data  <= fir_b;
            if (w_underrun_set) begin
                underrun <= 1'b1;
            end else if (clr_err) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_stream_ctrl
//  Description : Self-checking bench for fir_stream_ctrl with a behavioural
//                6-tap transposed FIR core of latency 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_stream_ctrl;

    typedef logic signed [15:0] samp_q_t [$];
    typedef struct {
        bit          v;
        logic [15:0] d;
        bit          l;
    } drv_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [15:0] fir_a;
    logic [25:0] fir_b;
    logic        out_valid;
    logic [25:0] out_data;
    logic        out_last;
    logic        busy;
    logic        underrun;
    logic        clr_err = 1'b0;

    logic        p8_valid = 1'b0;
    logic        p8_ready;
    logic [15:0] p8_data = '0;
    logic [15:0] p8_fir_a;
    logic        p8_out_valid;
    logic [25:0] p8_out_data;
    logic        p8_out_last;
    logic        p8_busy;
    logic        p8_underrun;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g_busy_cyc;
    int g_start;

    fir_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .fir_a(fir_a), .fir_b(fir_b),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .underrun(underrun), .clr_err(clr_err)
    );

    fir_stream_ctrl #(.PRIME(8)) dut_p8 (
        .clk(clk), .rst_n(rst_n), .in_valid(p8_valid), .in_ready(p8_ready),
        .in_data(p8_data), .in_last(1'b0), .fir_a(p8_fir_a), .fir_b(26'd0),
        .out_valid(p8_out_valid), .out_data(p8_out_data), .out_last(p8_out_last),
        .busy(p8_busy), .underrun(p8_underrun), .clr_err(1'b0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core coefficients
    function automatic int hc(input int k);
        case (k)
            0: return 2;
            1: return -3;
            2: return 5;
            3: return 7;
            4: return -1;
            5: return 4;
            default: return 0;
        endcase
    endfunction

    // Behavioural transposed FIR core: input register then adder chain.
    logic signed [15:0] core_a;
    logic signed [25:0] z [6];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_a <= '0;
            for (int k = 0; k < 6; k++) z[k] <= '0;
        end else begin
            core_a <= $signed(fir_a);
            for (int k = 0; k < 5; k++) z[k] <= 26'(int'(core_a) * hc(k) + int'(z[k+1]));
            z[5] <= 26'(int'(core_a) * hc(5));
        end
    end
    assign fir_b = z[0];

    function automatic longint conv(input samp_q_t x, input int k);
        longint s = 0;
        for (int j = 0; j < 6; j++) begin
            if ((k - j >= 0) && (k - j < x.size())) s += longint'(hc(j)) * longint'(x[k-j]);
        end
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input drv_t q[$]);
        foreach (q[i]) begin
            in_valid = q[i].v;
            in_data  = q[i].d;
            in_last  = q[i].l;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Waits for a frame of x.size()+5 outputs and checks every one of them.
    task automatic check_frame(input string tag, input samp_q_t x,
                               input bit chk_lat, input bit chk_idle);
        int n      = x.size() + 5;
        int t      = 0;
        int busy_c = -1;
        do begin
            @(negedge clk);
            if (busy && busy_c < 0) busy_c = cyc;
            t++;
        end while (!out_valid && t < 80);
        if (!out_valid) begin
            check_eq({tag, "_timeout"}, out_valid, 1);
            return;
        end
        g_busy_cyc = busy_c;
        if (chk_lat) check_eq({tag, "_first_valid_lat"}, cyc - busy_c, 3);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            check_eq($sformatf("%s_valid[%0d]", tag, i), out_valid, 1);
            check_eq($sformatf("%s_data[%0d]", tag, i), $signed(out_data), conv(x, i));
            check_eq($sformatf("%s_last[%0d]", tag, i), out_last, (i == n - 1) ? 1 : 0);
        end
        @(negedge clk);
        check_eq({tag, "_valid_after"}, out_valid, 0);
        if (chk_idle) check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        drv_t    q[$];
        samp_q_t xs, xb;
        int      busy_seen;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_fir_a", fir_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);

        // ---------------- full FIFO (PRIME=8 instance) ----------------
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            p8_valid = 1'b1;
            p8_data  = 16'(i + 1);
            @(negedge clk);
            if (i == 7) check_eq("full_ready_at7", p8_ready, 1);
            @(posedge clk); #1;
        end
        p8_valid = 1'b0;
        @(negedge clk);
        check_eq("full_ready_at8", p8_ready, 0);
        check_eq("full_idle_at8", p8_busy, 0);
        @(negedge clk);
        check_eq("full_ready_run1", p8_ready, 0);
        check_eq("full_run_started", p8_busy, 1);
        check_eq("full_fir_a_head", p8_fir_a, 1);
        @(negedge clk);
        check_eq("full_ready_after_pop", p8_ready, 1);

        // ---------------- impulse ----------------
        @(posedge clk); #1;
        xs = {16'sd1000};
        q = {};
        q.push_back('{1'b1, 16'd1000, 1'b1});
        g_start = cyc;
        fork
            drive(q);
            check_frame("impulse", xs, 1'b1, 1'b1);
        join
        check_eq("impulse_run_start", g_busy_cyc - g_start, 2);

        // ---------------- steady 4-sample frame ----------------
        repeat (2) @(posedge clk); #1;
        xs = {16'sd100, -16'sd200, 16'sd300, -16'sd400};
        q = {};
        foreach (xs[i]) q.push_back('{1'b1, xs[i], (i == 3)});
        g_start = cyc;
        fork
            drive(q);
            check_frame("steady", xs, 1'b1, 1'b1);
        join
        check_eq("steady_run_start", g_busy_cyc - g_start, 5);
        check_eq("steady_no_underrun", underrun, 0);

        // ---------------- underrun ----------------
        repeat (2) @(posedge clk); #1;
        q = {};
        for (int i = 0; i < 4; i++) q.push_back('{1'b1, 16'(50 * (i + 1)), 1'b0});
        for (int i = 0; i < 7; i++) q.push_back('{1'b0, 16'd0, 1'b0});
        q.push_back('{1'b1, 16'hFF38, 1'b1});   // -200
        xs = {16'sd50, 16'sd100, 16'sd150, 16'sd200, 16'sd0, 16'sd0, 16'sd0, -16'sd200};
        fork
            drive(q);
            check_frame("underrun", xs, 1'b1, 1'b1);
        join
        check_eq("underrun_flag_set", underrun, 1);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check_eq("underrun_cleared", underrun, 0);

        // ---------------- back-to-back frames ----------------
        @(posedge clk); #1;
        xs = {16'sd500, -16'sd700};
        xb = {16'sd1200, 16'sd300, -16'sd900};
        q = {};
        q.push_back('{1'b1, 16'd500, 1'b0});
        q.push_back('{1'b1, 16'hFD44, 1'b1});   // -700
        q.push_back('{1'b1, 16'd1200, 1'b0});
        q.push_back('{1'b1, 16'd300, 1'b0});
        q.push_back('{1'b1, 16'hFC7C, 1'b1});   // -900
        fork
            drive(q);
            begin
                check_frame("b2b_A", xs, 1'b1, 1'b0);
                check_frame("b2b_B", xb, 1'b0, 1'b1);
            end
        join

        // ---------------- reset mid-frame ----------------
        @(posedge clk); #1;
        q = {};
        for (int i = 0; i < 7; i++) q.push_back('{1'b1, 16'(11 * (i + 1)), 1'b0});
        drive(q);                       // returns at the start of cycle 7
        repeat (2) @(posedge clk); #1;  // cycle 9: s4 at the head, 3 queued
        check_eq("mid_busy", busy, 1);
        check_eq("mid_out_valid", out_valid, 1);
        check_eq("mid_fir_a", fir_a, 55);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_out_last", out_last, 0);
        check_eq("arst_out_data", out_data, 0);
        check_eq("arst_fir_a", fir_a, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check_eq("post_rst_fifo_empty", busy_seen, 0);
        @(posedge clk); #1;
        xs = {-16'sd1234};
        q = {};
        q.push_back('{1'b1, 16'hFB2E, 1'b1});   // -1234
        fork
            drive(q);
            check_frame("post_rst", xs, 1'b1, 1'b1);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
